// File: rtl/div_share_arbiter_pkg.sv
// Shared types for the divider-sharing arbiter: tag type, STAR/O vector formats and sizing defaults.
// Vector elements are signed Q8.8 fixed point.
`ifndef NUM_DIV_REQ
`define NUM_DIV_REQ 4
`endif
`ifndef DIV_MAX_INFLIGHT
`define DIV_MAX_INFLIGHT 4
`endif

package div_share_arbiter_pkg;

  localparam int NUM_DIV_REQ      = `NUM_DIV_REQ;
  localparam int DIV_MAX_INFLIGHT = `DIV_MAX_INFLIGHT;
  localparam int DIV_TAG_W        = $clog2(NUM_DIV_REQ);

  localparam int VEC_ELEM_W = 16;
  localparam int STAR_LEN   = 4;
  localparam int O_LEN      = STAR_LEN - 1;

  typedef logic [DIV_TAG_W-1:0]  DIV_TAG_T;
  typedef logic [VEC_ELEM_W-1:0] VEC_ELEM_T;

  // Element 0 of a STAR vector is the denominator; the rest are numerators.
  typedef VEC_ELEM_T [STAR_LEN-1:0] STAR_VECTOR_T;
  typedef VEC_ELEM_T [O_LEN-1:0]    O_VECTOR_T;

  localparam int STAR_W = $bits(STAR_VECTOR_T);
  localparam int O_W    = $bits(O_VECTOR_T);

endpackage

// File: rtl/div_tag_fifo.sv
// In-order FIFO of requester tags, one entry per vector outstanding inside the divider.
// Push/pop are qualified internally so a push when full or pop when empty is ignored.
module div_tag_fifo
  import div_share_arbiter_pkg::*;
#(
  parameter int W     = DIV_TAG_W,
  parameter int DEPTH = DIV_MAX_INFLIGHT,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_tag,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one in-order vector divider among NUM_REQ requesters.
// Issued requester indices ride a tag FIFO so each result is steered back to its issuer.
module div_share_arbiter
  import div_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_DIV_REQ,
  parameter int MAX_INFLIGHT = DIV_MAX_INFLIGHT,
  localparam int TAG_W = $clog2(NUM_REQ),
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_rdy,
  input  logic [NUM_REQ-1:0][STAR_W-1:0]  req_vec,
  output logic                            div_vld_in,
  input  logic                            div_rdy_out,
  output logic [STAR_W-1:0]               div_vec_in,
  input  logic                            div_vld_out,
  output logic                            div_rdy_in,
  input  logic [O_W-1:0]                  div_vec_out,
  output logic [NUM_REQ-1:0]              rsp_vld,
  input  logic [NUM_REQ-1:0]              rsp_rdy,
  output logic [O_W-1:0]                  rsp_vec,
  output logic [CNT_W-1:0]                inflight
);

  logic [TAG_W-1:0]     rr_ptr;
  logic [TAG_W-1:0]     grant;
  logic                 any_vld;
  logic [2*NUM_REQ-1:0] dbl_req;
  logic                 can_issue;
  logic                 issue;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [TAG_W-1:0]     head;

  assign dbl_req = {req_vld, req_vld};

  // The upper copy of req_vld supplies the wrapped-around candidates, so the
  // lowest set bit at or above rr_ptr is the round-robin winner.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant   = '0;
    any_vld = 1'b0;
    for (int i = 2*NUM_REQ - 1; i >= 0; i--) begin
      if (dbl_req[i] && (i >= int'(rr_ptr))) begin
        any_vld = 1'b1;
        grant   = (i >= NUM_REQ) ? TAG_W'(i - NUM_REQ) : TAG_W'(i);
      end
    end
  end

  // Handshakes are forced idle while reset is held, not just after the next edge.
  assign can_issue  = rst && any_vld && !fifo_full;
  assign issue      = can_issue && div_rdy_out;
  assign div_vld_in = can_issue;
  assign div_vec_in = can_issue ? req_vec[grant] : '0;

  always_comb begin
    req_rdy = '0;
    if (issue) req_rdy[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rr_ptr <= '0;
    else if (issue) rr_ptr <= (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  end

  div_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (issue),
    .push_tag (grant),
    .pop      (div_vld_out && div_rdy_in),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head),
    .count    (inflight)
  );

  always_comb begin
    rsp_vld = '0;
    if (!fifo_empty) rsp_vld[head] = div_vld_out;
  end

  assign div_rdy_in = !fifo_empty && rsp_rdy[head];
  assign rsp_vec    = div_vec_out;

  // A divider result with no outstanding tag has no owner and is never accepted.
  a_result_has_tag: assert property (@(posedge clk) disable iff (!rst)
    !(div_vld_out && fifo_empty));

endmodule
